// File: rtl/imem.sv
// Word-addressed memory with registered read port. Reset asynchronously clears
// every word and the read register; rw=1 reads, rw=0 writes.
module imem #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              rw,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DATA_W-1:0] data_out_q;
  logic [DATA_W-1:0] data_out_d;

  always_comb begin
    mem_d      = mem_q;
    data_out_d = data_out_q;
    if (rw) begin
      data_out_d = mem_q[address];
    end else begin
      mem_d[address] = data_in;
    end
  end

  // Storage lives in resettable flops so reset can clear every word without a clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      data_out_q <= '0;
    end else begin
      mem_q      <= mem_d;
      data_out_q <= data_out_d;
    end
  end

  assign data_out = data_out_q;

endmodule

// File: tb/tb_imem.sv
// Directed-vector bench for imem: hand-computed expected read data after each
// write/read/reset sequence.
module tb_imem;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 32;

  logic              clk;
  logic              reset;
  logic [ADDR_W-1:0] address;
  logic              rw;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;

  int unsigned n_cmp;
  int unsigned n_bad;

  imem #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .address  (address),
    .rw       (rw),
    .data_in  (data_in),
    .data_out (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DATA_W-1:0] got,
                     input logic [DATA_W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One rising edge, then settle 1 ns past it before sampling.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    rw = 1'b0; address = a; data_in = d;
    cyc();
  endtask

  task automatic rd(input logic [ADDR_W-1:0] a);
    rw = 1'b1; address = a;
    cyc();
  endtask

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    reset   = 1'b0;
    rw      = 1'b1;
    address = '0;
    data_in = '0;
    cyc();
    chk("reset_state", data_out, 32'h0);
    reset = 1'b1;

    wr(5'd1, 32'h0016_8693);
    chk("write_keeps_out", data_out, 32'h0);
    rd(5'd1);
    chk("rd_a1_first", data_out, 32'h0016_8693);

    #2 reset = 1'b0;
    #1 chk("async_clear_out", data_out, 32'h0);
    reset = 1'b1;
    rd(5'd1);
    chk("rd_a1_after_rst", data_out, 32'h0);

    wr(5'd1, 32'h0000_0713);
    rd(5'd1);
    chk("rd_a1_second", data_out, 32'h0000_0713);
    rd(5'd2);
    chk("rd_a2_unwritten", data_out, 32'h0);

    wr(5'd0, 32'hA5A5_0000);
    wr(5'd31, 32'h0000_5A5A);
    rd(5'd0);
    chk("rd_a0", data_out, 32'hA5A5_0000);
    rd(5'd31);
    chk("rd_a31", data_out, 32'h0000_5A5A);
    cyc();
    cyc();
    chk("hold_read", data_out, 32'h0000_5A5A);

    wr(5'd3, 32'h1);
    data_in = 32'h2; cyc();
    data_in = 32'h3; cyc();
    rd(5'd3);
    chk("rewrite_each_edge", data_out, 32'h3);

    // Glitch the controls between edges; only edge-time values may matter.
    #2 rw = 1'b0; address = 5'd3; data_in = 32'hDEAD_BEEF;
    #1 rw = 1'b1; address = 5'd0;
    cyc();
    chk("glitch_read_a0", data_out, 32'hA5A5_0000);
    rd(5'd3);
    chk("glitch_no_write", data_out, 32'h3);

    reset = 1'b0;
    rw = 1'b0; address = 5'd7; data_in = 32'hFFFF_FFFF;
    cyc(); cyc(); cyc();
    chk("rst_held_out", data_out, 32'h0);
    reset = 1'b1;
    rd(5'd7);
    chk("rst_blocks_write", data_out, 32'h0);
    rd(5'd31);
    chk("rst_cleared_a31", data_out, 32'h0);

    reset = 1'b0;
    #2 reset = 1'b1;
    wr(5'd9, 32'h0BAD_F00D);
    rd(5'd9);
    chk("first_edge_write", data_out, 32'h0BAD_F00D);

    wr(5'd5, 32'h1234_5678);
    rd(5'd5);
    chk("rd_a5_x", data_out, 32'h1234_5678);
    wr(5'd5, 32'hCAFE_F00D);
    chk("out_held_on_write", data_out, 32'h1234_5678);
    rd(5'd5);
    chk("rd_a5_y", data_out, 32'hCAFE_F00D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
